// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    // Smallest r such that 2**r >= v.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < {32'd0, v}) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned pow10(input int d);
        int unsigned p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One reverse double-dabble step: shift {bcd, bin} right by one, then
// pull every BCD digit that landed at 8 or above back down by 3.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [8*DIGITS-1:0] sreg_cur,
    output logic [8*DIGITS-1:0] sreg_next
);

    logic [8*DIGITS-1:0] shifted;

    always_comb begin
        shifted   = sreg_cur >> 1;
        sreg_next = shifted;
        for (int d = 0; d < DIGITS; d++) begin
            if (shifted[4*DIGITS + 4*d +: 4] >= 4'd8)
                sreg_next[4*DIGITS + 4*d +: 4] = shifted[4*DIGITS + 4*d +: 4] - 4'd3;
        end
    end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Multi-cycle BCD-to-binary converter with valid/ready handshakes on both
// sides; one word in flight, bad nibbles short-circuit straight to DONE.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int BIN_W  = clog2(pow10(DIGITS))
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err_out,
    output logic                  busy
);

    localparam int              CNT_W = clog2(4*DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(4*DIGITS - 1);

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [8*DIGITS-1:0] sreg;
    logic [8*DIGITS-1:0] step_out;
    logic [BIN_W-1:0]    bin_q;
    logic                err_q;
    logic                bad_nibble;

    function automatic logic has_bad_nibble(input logic [4*DIGITS-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (w[4*d +: 4] > BCD_DIGIT_MAX) bad = 1'b1;
        end
        return bad;
    endfunction

    assign bad_nibble = has_bad_nibble(bcd_in);

    bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
        .sreg_cur  (sreg),
        .sreg_next (step_out)
    );

    // Result registers only change on entry to DONE so they stay put while
    // the consumer stalls and across the following IDLE/SHIFT period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            bin_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg <= {bcd_in, {(4*DIGITS){1'b0}}};
                        cnt  <= '0;
                        if (bad_nibble) begin
                            state <= DONE;
                            err_q <= 1'b1;
                            bin_q <= '0;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sreg <= step_out;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state <= DONE;
                        err_q <= 1'b0;
                        bin_q <= step_out[BIN_W-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign bin_out   = bin_q;
    assign err_out   = err_q;

endmodule
